jtcop_mcu_bridge: RTL and testbench

JTCOP_MCU_BRIDGE -- requirements
Module: jtcop_mcu_bridge

---
 rtl/jtcop_mcu_bridge.sv | 129 ++++++++++++
 tb/tb_jtcop_mcu_bridge.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_mcu_bridge.sv
// CPU <-> MCU mailbox bridge: per-channel command/response registers shared by a
// wide CPU bus and an 8-bit MCU port, with pending/overrun flags and an MCU interrupt.
module jtcop_mcu_bridge #(
  parameter int DW = 16,
  parameter int NCH = 2,
  parameter logic [NCH-1:0] IRQMASK = {NCH{1'b1}},
  localparam int NB = DW / 8,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cs,
  input  logic          cpu_rnw,
  input  logic [CW-1:0] cpu_ch,
  input  logic [NB-1:0] cpu_dsn,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  input  logic [CW-1:0] mcu_ch,
  input  logic [NB-1:0] mcu_rd,
  input  logic [NB-1:0] mcu_wr,
  input  logic [7:0]    mcu_dout,
  output logic [7:0]    mcu_din,
  input  logic          mcu_ack,
  output logic          mcu_intn,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] ovr
);

  logic [DW-1:0] cmd [NCH];
  logic [DW-1:0] rsp [NCH];

  logic [NB-1:0] rd_q;
  logic [NB-1:0] wr_q;
  logic          cpu_wr_q;

  logic          cpu_wr;
  logic          accept;
  logic [NB-1:0] rd_rise;
  logic [NB-1:0] wr_rise;

  logic          cpu_ok;
  logic          cpu_irq;
  logic [DW-1:0] rsp_sel;
  logic [DW-1:0] cmd_sel;
  logic [7:0]    rd_byte;

  assign cpu_wr  = cpu_cs & ~cpu_rnw;
  assign accept  = cpu_wr & ~cpu_wr_q & cpu_ok;
  assign rd_rise = mcu_rd & ~rd_q;
  assign wr_rise = mcu_wr & ~wr_q;

  // Channel decode by comparison keeps out-of-range selects from indexing the arrays.
  always_comb begin
    cpu_ok  = 1'b0;
    cpu_irq = 1'b0;
    rsp_sel = '0;
    cmd_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cpu_ch == CW'(c)) begin
        cpu_ok  = 1'b1;
        cpu_irq = IRQMASK[c];
        rsp_sel = rsp[c];
      end
      if (mcu_ch == CW'(c)) begin
        cmd_sel = cmd[c];
      end
    end
  end

  // Descending scan so the lowest rising lane is the one that sticks.
  always_comb begin
    rd_byte = 8'h00;
    for (int k = NB - 1; k >= 0; k--) begin
      if (rd_rise[k]) begin
        rd_byte = cmd_sel[8*k +: 8];
      end
    end
  end

  // Edge-detect copies track the inputs even in reset, so held strobes never look new.
  always_ff @(posedge clk) begin
    rd_q     <= mcu_rd;
    wr_q     <= mcu_wr;
    cpu_wr_q <= cpu_wr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_dout <= '0;
      mcu_din  <= 8'h00;
      mcu_intn <= 1'b1;
      pending  <= '0;
      ovr      <= '0;
      for (int c = 0; c < NCH; c++) begin
        cmd[c] <= '0;
        rsp[c] <= '0;
      end
    end else begin
      cpu_dout <= rsp_sel;
      if (|rd_rise) begin
        mcu_din <= rd_byte;
      end
      if (!mcu_ack) begin
        mcu_intn <= 1'b1;
      end else if (accept && cpu_irq) begin
        mcu_intn <= 1'b0;
      end
      for (int c = 0; c < NCH; c++) begin
        // A CPU write beats a simultaneous MCU read-clear on the same channel.
        if (accept && cpu_ch == CW'(c)) begin
          pending[c] <= 1'b1;
          ovr[c]     <= ovr[c] | pending[c];
        end else if (rd_rise[0] && mcu_ch == CW'(c)) begin
          pending[c] <= 1'b0;
          ovr[c]     <= 1'b0;
        end
        for (int k = 0; k < NB; k++) begin
          if (accept && cpu_ch == CW'(c) && !cpu_dsn[k]) begin
            cmd[c][8*k +: 8] <= cpu_din[8*k +: 8];
          end
          if (wr_rise[k] && mcu_ch == CW'(c)) begin
            rsp[c][8*k +: 8] <= mcu_dout;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtcop_mcu_bridge.sv
// Self-checking bench for jtcop_mcu_bridge (DW=16, NCH=2): a byte-array mailbox model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_jtcop_mcu_bridge;

  typedef struct {
    logic        rst;
    logic        cs;
    logic        rnw;
    logic [0:0]  cch;
    logic [1:0]  dsn;
    logic [15:0] din;
    logic [0:0]  mch;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [7:0]  mdout;
    logic        ack;
  } stim_t;

  localparam logic [1:0] MASK_A = 2'b11;
  localparam logic [1:0] MASK_B = 2'b01;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cs;
  logic        cpu_rnw;
  logic [0:0]  cpu_ch;
  logic [1:0]  cpu_dsn;
  logic [15:0] cpu_din;
  logic [0:0]  mcu_ch;
  logic [1:0]  mcu_rd;
  logic [1:0]  mcu_wr;
  logic [7:0]  mcu_dout;
  logic        mcu_ack;

  logic [15:0] cpu_dout_a, cpu_dout_b;
  logic [7:0]  mcu_din_a, mcu_din_b;
  logic        mcu_intn_a, mcu_intn_b;
  logic [1:0]  pending_a, pending_b;
  logic [1:0]  ovr_a, ovr_b;

  int checks = 0;
  int errors = 0;

  stim_t base;

  always #5 clk = ~clk;

  jtcop_mcu_bridge #(.DW(16), .NCH(2), .IRQMASK(MASK_A)) dut_a (
    .clk(clk), .rst(rst), .cpu_cs(cpu_cs), .cpu_rnw(cpu_rnw), .cpu_ch(cpu_ch),
    .cpu_dsn(cpu_dsn), .cpu_din(cpu_din), .cpu_dout(cpu_dout_a), .mcu_ch(mcu_ch),
    .mcu_rd(mcu_rd), .mcu_wr(mcu_wr), .mcu_dout(mcu_dout), .mcu_din(mcu_din_a),
    .mcu_ack(mcu_ack), .mcu_intn(mcu_intn_a), .pending(pending_a), .ovr(ovr_a)
  );

  jtcop_mcu_bridge #(.DW(16), .NCH(2), .IRQMASK(MASK_B)) dut_b (
    .clk(clk), .rst(rst), .cpu_cs(cpu_cs), .cpu_rnw(cpu_rnw), .cpu_ch(cpu_ch),
    .cpu_dsn(cpu_dsn), .cpu_din(cpu_din), .cpu_dout(cpu_dout_b), .mcu_ch(mcu_ch),
    .mcu_rd(mcu_rd), .mcu_wr(mcu_wr), .mcu_dout(mcu_dout), .mcu_din(mcu_din_b),
    .mcu_ack(mcu_ack), .mcu_intn(mcu_intn_b), .pending(pending_b), .ovr(ovr_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Mailbox model: bytes per channel/lane, flags per channel, one interrupt per mask.
  logic [7:0] m_cmd [2][2];
  logic [7:0] m_rsp [2][2];
  logic [1:0] m_pend = 2'b00;
  logic [1:0] m_ovr  = 2'b00;
  logic [7:0] m_din  = 8'h00;
  logic [15:0] m_dout = 16'h0000;
  logic       m_intn [2];
  logic [1:0] p_rd = 2'b00;
  logic [1:0] p_wr = 2'b00;
  logic       p_cw = 1'b0;

  always @(posedge clk) begin : model
    logic [1:0] rd_rise;
    logic [1:0] wr_rise;
    logic       acc;
    logic       old_p;
    logic [1:0] mask;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 2; k++) begin
          m_cmd[c][k] = 8'h00;
          m_rsp[c][k] = 8'h00;
        end
        m_intn[c] = 1'b1;
      end
      m_pend = 2'b00;
      m_ovr  = 2'b00;
      m_din  = 8'h00;
      m_dout = 16'h0000;
    end else begin
      rd_rise = mcu_rd & ~p_rd;
      wr_rise = mcu_wr & ~p_wr;
      acc     = cpu_cs && !cpu_rnw && !p_cw;
      m_dout  = {m_rsp[cpu_ch][1], m_rsp[cpu_ch][0]};
      if (rd_rise != 2'b00) m_din = rd_rise[0] ? m_cmd[mcu_ch][0] : m_cmd[mcu_ch][1];
      old_p = m_pend[cpu_ch];
      if (rd_rise[0]) begin
        m_pend[mcu_ch] = 1'b0;
        m_ovr[mcu_ch]  = 1'b0;
      end
      if (acc) begin
        m_ovr[cpu_ch]  = old_p;
        m_pend[cpu_ch] = 1'b1;
        for (int k = 0; k < 2; k++)
          if (!cpu_dsn[k]) m_cmd[cpu_ch][k] = cpu_din[8*k +: 8];
      end
      for (int k = 0; k < 2; k++)
        if (wr_rise[k]) m_rsp[mcu_ch][k] = mcu_dout;
      for (int i = 0; i < 2; i++) begin
        mask = (i == 0) ? MASK_A : MASK_B;
        if (!mcu_ack) m_intn[i] = 1'b1;
        else if (acc && mask[cpu_ch]) m_intn[i] = 1'b0;
      end
    end
    p_rd = mcu_rd;
    p_wr = mcu_wr;
    p_cw = cpu_cs & ~cpu_rnw;
    #1;
    checkOutput("cpu_dout_a", 32'(cpu_dout_a), 32'(m_dout));
    checkOutput("mcu_din_a", 32'(mcu_din_a), 32'(m_din));
    checkOutput("pending_a", 32'(pending_a), 32'(m_pend));
    checkOutput("ovr_a", 32'(ovr_a), 32'(m_ovr));
    checkOutput("mcu_intn_a", 32'(mcu_intn_a), 32'(m_intn[0]));
    checkOutput("cpu_dout_b", 32'(cpu_dout_b), 32'(m_dout));
    checkOutput("mcu_din_b", 32'(mcu_din_b), 32'(m_din));
    checkOutput("pending_b", 32'(pending_b), 32'(m_pend));
    checkOutput("ovr_b", 32'(ovr_b), 32'(m_ovr));
    checkOutput("mcu_intn_b", 32'(mcu_intn_b), 32'(m_intn[1]));
  end

  task automatic applyStimulus(input stim_t v);
    rst      = v.rst;
    cpu_cs   = v.cs;
    cpu_rnw  = v.rnw;
    cpu_ch   = v.cch;
    cpu_dsn  = v.dsn;
    cpu_din  = v.din;
    mcu_ch   = v.mch;
    mcu_rd   = v.rd;
    mcu_wr   = v.wr;
    mcu_dout = v.mdout;
    mcu_ack  = v.ack;
    @(negedge clk);
  endtask

  task automatic cpuWrite(input logic [0:0] ch, input logic [1:0] dsn, input logic [15:0] data);
    stim_t v;
    v = base;
    v.cs = 1'b1; v.rnw = 1'b0; v.cch = ch; v.dsn = dsn; v.din = data;
    applyStimulus(v);
    applyStimulus(base);
  endtask

  task automatic mcuRead(input logic [0:0] ch, input logic [1:0] lanes);
    stim_t v;
    v = base;
    v.mch = ch; v.rd = lanes;
    applyStimulus(v);
    v.rd = 2'b00;
    applyStimulus(v);
  endtask

  task automatic mcuWrite(input logic [0:0] ch, input logic [1:0] lanes, input logic [7:0] b);
    stim_t v;
    v = base;
    v.mch = ch; v.wr = lanes; v.mdout = b;
    applyStimulus(v);
    v.wr = 2'b00;
    applyStimulus(v);
  endtask

  task automatic ackPulse();
    stim_t v;
    v = base;
    v.ack = 1'b0;
    applyStimulus(v);
    applyStimulus(base);
  endtask

  initial begin : stimulus
    stim_t v;
    base = '{rst: 1'b1, cs: 1'b0, rnw: 1'b1, cch: 1'b0, dsn: 2'b11, din: 16'h0000,
             mch: 1'b0, rd: 2'b00, wr: 2'b00, mdout: 8'h00, ack: 1'b1};
    repeat (3) applyStimulus(base);
    checkOutput("reset pending", 32'(pending_a), 32'h0);
    checkOutput("reset intn", 32'(mcu_intn_a), 32'h1);
    checkOutput("reset cpu_dout", 32'(cpu_dout_a), 32'h0);
    base.rst = 1'b0;
    applyStimulus(base);

    // Full-word command to ch1, read back lane by lane.
    cpuWrite(1'b1, 2'b00, 16'hA55A);
    checkOutput("wr ch1 pending", 32'(pending_a), 32'h2);
    checkOutput("wr ch1 intn_a", 32'(mcu_intn_a), 32'h0);
    checkOutput("wr ch1 intn_b", 32'(mcu_intn_b), 32'h1);
    mcuRead(1'b1, 2'b10);
    checkOutput("rd lane1", 32'(mcu_din_a), 32'hA5);
    checkOutput("rd lane1 pending", 32'(pending_a), 32'h2);
    mcuRead(1'b1, 2'b01);
    checkOutput("rd lane0", 32'(mcu_din_a), 32'h5A);
    checkOutput("rd lane0 pending", 32'(pending_a), 32'h0);
    ackPulse();
    checkOutput("ack release", 32'(mcu_intn_a), 32'h1);

    // Response assembled byte by byte, then CPU readback per channel.
    mcuWrite(1'b0, 2'b01, 8'h34);
    mcuWrite(1'b0, 2'b10, 8'h12);
    checkOutput("rsp ch0", 32'(cpu_dout_a), 32'h1234);
    base.cs = 1'b1; base.cch = 1'b1;
    applyStimulus(base);
    checkOutput("rsp ch1", 32'(cpu_dout_a), 32'h0000);
    base.cch = 1'b0;
    applyStimulus(base);
    checkOutput("rsp ch0 again", 32'(cpu_dout_a), 32'h1234);
    base.cs = 1'b0;

    // MCU writes the register being read: old value now, new value next cycle.
    v = base; v.mch = 1'b0; v.wr = 2'b01; v.mdout = 8'h99;
    applyStimulus(v);
    checkOutput("rsp race old", 32'(cpu_dout_a), 32'h1234);
    v.wr = 2'b00;
    applyStimulus(v);
    checkOutput("rsp race new", 32'(cpu_dout_a), 32'h1299);

    // Overrun: two commands before the MCU reads.
    cpuWrite(1'b0, 2'b00, 16'h0001);
    cpuWrite(1'b0, 2'b00, 16'h0002);
    checkOutput("ovr pending", 32'(pending_a), 32'h1);
    checkOutput("ovr set", 32'(ovr_a), 32'h1);
    checkOutput("ovr intn_b", 32'(mcu_intn_b), 32'h0);
    mcuRead(1'b0, 2'b01);
    checkOutput("ovr data", 32'(mcu_din_a), 32'h02);
    checkOutput("ovr cleared", 32'(ovr_a), 32'h0);
    mcuRead(1'b0, 2'b10);
    checkOutput("ovr hi byte", 32'(mcu_din_a), 32'h00);

    // A long write is taken once, on its first cycle.
    v = base; v.cs = 1'b1; v.rnw = 1'b0; v.dsn = 2'b00; v.din = 16'h1311;
    applyStimulus(v);
    v.din = 16'h2222;
    applyStimulus(v);
    applyStimulus(base);
    checkOutput("long wr ovr", 32'(ovr_a), 32'h0);
    mcuRead(1'b0, 2'b11);
    checkOutput("both lanes lowest", 32'(mcu_din_a), 32'h11);
    mcuRead(1'b0, 2'b10);
    checkOutput("long wr hi", 32'(mcu_din_a), 32'h13);

    // Same-cycle CPU write and MCU read-clear on ch0.
    v = base; v.cs = 1'b1; v.rnw = 1'b0; v.dsn = 2'b00; v.din = 16'h4444; v.rd = 2'b01;
    applyStimulus(v);
    checkOutput("race din old", 32'(mcu_din_a), 32'h11);
    checkOutput("race pending", 32'(pending_a), 32'h1);
    checkOutput("race ovr", 32'(ovr_a), 32'h0);
    applyStimulus(base);
    v.din = 16'h5555;
    applyStimulus(v);
    checkOutput("race2 din old", 32'(mcu_din_a), 32'h44);
    checkOutput("race2 ovr", 32'(ovr_a), 32'h1);
    applyStimulus(base);
    mcuRead(1'b0, 2'b01);
    checkOutput("race2 data", 32'(mcu_din_a), 32'h55);

    // Interrupt masking and ack priority.
    ackPulse();
    cpuWrite(1'b1, 2'b00, 16'h0F0F);
    checkOutput("mask ch1 b", 32'(mcu_intn_b), 32'h1);
    checkOutput("mask ch1 a", 32'(mcu_intn_a), 32'h0);
    base.ack = 1'b0;
    cpuWrite(1'b0, 2'b00, 16'h0A0A);
    checkOutput("ack hold b", 32'(mcu_intn_b), 32'h1);
    checkOutput("ack hold a", 32'(mcu_intn_a), 32'h1);
    base.ack = 1'b1;
    applyStimulus(base);
    cpuWrite(1'b0, 2'b00, 16'h0B0B);
    checkOutput("irq ch0 b", 32'(mcu_intn_b), 32'h0);

    // Strobes and a CPU write held across reset release produce nothing.
    base.rst = 1'b1; base.rd = 2'b11; base.cs = 1'b1; base.rnw = 1'b0;
    base.dsn = 2'b00; base.din = 16'hFFFF;
    repeat (2) applyStimulus(base);
    checkOutput("rst mid intn", 32'(mcu_intn_b), 32'h1);
    base.rst = 1'b0;
    repeat (2) applyStimulus(base);
    checkOutput("post rst pending", 32'(pending_a), 32'h0);
    checkOutput("post rst din", 32'(mcu_din_a), 32'h00);
    base.rd = 2'b00; base.cs = 1'b0; base.rnw = 1'b1; base.dsn = 2'b11;
    applyStimulus(base);
    cpuWrite(1'b0, 2'b10, 16'hBEEF);
    checkOutput("lane wr pending", 32'(pending_a), 32'h1);
    mcuRead(1'b0, 2'b10);
    checkOutput("lane wr hi", 32'(mcu_din_a), 32'h00);
    mcuRead(1'b0, 2'b01);
    checkOutput("lane wr lo", 32'(mcu_din_a), 32'hEF);

    repeat (2) applyStimulus(base);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
